// File: rtl/core_inst_queue_pkg.sv
// Shared pipeline types for the fetch-to-decode instruction queue.
package core_inst_queue_pkg;

  // Branch predictor result carried alongside each fetched instruction.
  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } bpu_predict_t;

  // Exception detected during fetch (e.g. page fault, access fault).
  typedef struct packed {
    logic       valid;
    logic [3:0] cause;
  } fetch_excp_t;

  // One instruction package as it travels through the queue.
  typedef struct packed {
    logic [31:0]  pc;
    logic [31:0]  inst;
    fetch_excp_t  fetch_excp;
    bpu_predict_t bpu_predict;
  } inst_package_t;

endpackage

// File: rtl/core_inst_queue_if.sv
// Producer/consumer bundle for the 2-wide instruction queue.
//
// Handshake: a write group is accepted on a rising clk edge when
// write_valid_i && write_ready_o && !flush_i; write_ready_o guarantees room for
// a full 2-entry group. On the read side read_valid_o[k] flags lane k, and the
// consumer pops min(read_num_i, valid entries) whenever read_ready_i is high.
interface core_inst_queue_if #(
  parameter int DATA_WIDTH = 64
);
  logic                         flush_i;
  logic                         write_valid_i;
  logic                         write_ready_o;
  logic [1:0]                   write_num_i;
  logic [1:0][DATA_WIDTH-1:0]   write_data_i;
  logic [1:0]                   read_valid_o;
  logic                         read_ready_i;
  logic [1:0]                   read_num_i;
  logic [1:0][DATA_WIDTH-1:0]   read_data_o;

  // Driver side (fetch stage and decode stage together).
  modport master (
    output flush_i, write_valid_i, write_num_i, write_data_i, read_ready_i, read_num_i,
    input  write_ready_o, read_valid_o, read_data_o
  );

  // Queue side.
  modport slave (
    input  flush_i, write_valid_i, write_num_i, write_data_i, read_ready_i, read_num_i,
    output write_ready_o, read_valid_o, read_data_o
  );
endinterface

// File: rtl/core_inst_queue_bank.sv
// One storage bank: 1 write port, 1 asynchronous read port, no reset.
module core_inst_queue_bank #(
  parameter int DATA_WIDTH = 64,
  parameter int ENTRIES    = 8
)(
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(ENTRIES)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [$clog2(ENTRIES)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]      rdata
);
  logic [DATA_WIDTH-1:0] mem [ENTRIES];

  // Storage write; contents are left undefined after reset on purpose.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/core_inst_queue.sv
// 2-wide in / 2-wide out instruction queue with first-word fall-through.
// Entries are interleaved over two banks by index LSB, so consecutive lanes
// always hit different banks and each bank needs only one port per direction.
module core_inst_queue
  import core_inst_queue_pkg::*;
#(
  parameter int DATA_WIDTH = 64 + $bits(bpu_predict_t) + $bits(fetch_excp_t),
  parameter int DEPTH      = 16
)(
  input  logic             clk,
  input  logic             rst,
  core_inst_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = AW - 1;
  localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 2);

  logic [AW-1:0] rptr, wptr;
  logic [AW:0]   count;

  logic [1:0]    wnum, rnum;
  logic          accept;
  logic [AW:0]   wr_cnt, pop_cnt;
  logic          we_lane0, we_lane1;
  logic [AW-1:0] waddr0, waddr1, raddr0, raddr1;
  logic          wswap, rswap;

  logic                  b0_we, b1_we;
  logic [BW-1:0]         b0_waddr, b1_waddr, b0_raddr, b1_raddr;
  logic [DATA_WIDTH-1:0] b0_wdata, b1_wdata, b0_rdata, b1_rdata;

  // A full group must always fit, so readiness leaves two free slots.
  assign bus.write_ready_o = (count <= READY_MAX);
  assign bus.read_valid_o  = {count > (AW+1)'(1), count > (AW+1)'(0)};

  // Group sizes: 3 behaves as 2 on both sides; pops are clamped to occupancy.
  assign wnum    = (bus.write_num_i == 2'd3) ? 2'd2 : bus.write_num_i;
  assign rnum    = (bus.read_num_i  == 2'd3) ? 2'd2 : bus.read_num_i;
  assign accept  = bus.write_valid_i && bus.write_ready_o && !bus.flush_i;
  assign wr_cnt  = accept ? (AW+1)'(wnum) : '0;
  assign pop_cnt = !bus.read_ready_i ? '0 :
                   (count < (AW+1)'(rnum)) ? count : (AW+1)'(rnum);

  assign we_lane0 = accept && (wnum != 2'd0);
  assign we_lane1 = accept && (wnum == 2'd2);

  // Lane addresses wrap naturally in AW bits.
  assign waddr0 = wptr;
  assign waddr1 = wptr + AW'(1);
  assign raddr0 = rptr;
  assign raddr1 = rptr + AW'(1);
  assign wswap  = wptr[0];
  assign rswap  = rptr[0];

  // Steer each lane to the bank selected by its entry LSB.
  assign b0_we    = wswap ? we_lane1 : we_lane0;
  assign b1_we    = wswap ? we_lane0 : we_lane1;
  assign b0_waddr = wswap ? waddr1[AW-1:1] : waddr0[AW-1:1];
  assign b1_waddr = wswap ? waddr0[AW-1:1] : waddr1[AW-1:1];
  assign b0_wdata = wswap ? bus.write_data_i[1] : bus.write_data_i[0];
  assign b1_wdata = wswap ? bus.write_data_i[0] : bus.write_data_i[1];
  assign b0_raddr = rswap ? raddr1[AW-1:1] : raddr0[AW-1:1];
  assign b1_raddr = rswap ? raddr0[AW-1:1] : raddr1[AW-1:1];

  assign bus.read_data_o[0] = rswap ? b1_rdata : b0_rdata;
  assign bus.read_data_o[1] = rswap ? b0_rdata : b1_rdata;

  core_inst_queue_bank #(.DATA_WIDTH(DATA_WIDTH), .ENTRIES(DEPTH/2)) u_bank0 (
    .clk   (clk),
    .we    (b0_we),
    .waddr (b0_waddr),
    .wdata (b0_wdata),
    .raddr (b0_raddr),
    .rdata (b0_rdata)
  );

  core_inst_queue_bank #(.DATA_WIDTH(DATA_WIDTH), .ENTRIES(DEPTH/2)) u_bank1 (
    .clk   (clk),
    .we    (b1_we),
    .waddr (b1_waddr),
    .wdata (b1_wdata),
    .raddr (b1_raddr),
    .rdata (b1_rdata)
  );

  // Pointer and occupancy update; flush wins over any same-cycle traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (bus.flush_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      rptr  <= rptr + pop_cnt[AW-1:0];
      wptr  <= wptr + wr_cnt[AW-1:0];
      count <= count + wr_cnt - pop_cnt;
    end
  end
endmodule

// File: doc/core_inst_queue.md
CORE_INST_QUEUE -- requirements
Module: core_inst_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64+$bits(bpu_predict_t)+$bits(fetch_excp_t), meaning width of one instruction package.
REQ-002 SHALL have parameter DEPTH, default 16, meaning total entries; a power of two, >= 4.
REQ-003 SHALL have a single clock and an asynchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (asynchronous, active-high reset).
REQ-004 flush_i  input  1  discard all contents (branch redirect / rst_jmp).
REQ-005 write_valid_i  input  1  producer offers a write group this cycle.
REQ-006 write_ready_o  output  1  queue can accept a full 2-entry group.
REQ-007 write_num_i  input  2  entries in the group, 0..2, packed from lane 0.
REQ-008 write_data_i  input  2xDATA_WIDTH  write lanes 0 and 1.
REQ-009 read_valid_o  output  2  lane k holds a valid entry.
REQ-010 read_ready_i  input  1  consumer enables popping this cycle.
REQ-011 read_num_i  input  2  entries consumed this cycle, 0..2.
REQ-012 read_data_o  output  2xDATA_WIDTH  oldest entry on lane 0, next oldest on lane 1.

Function
REQ-013 SHALL keep a read pointer, a write pointer (log2(DEPTH) bits, modulo DEPTH wrap) and an occupancy count (log2(DEPTH)+1 bits).
REQ-014 write_ready_o SHALL be 1 iff count <= DEPTH-2, decoded combinationally from the registered count.
REQ-015 A write SHALL be accepted iff write_valid_i && write_ready_o && !flush_i; lane j < write_num_i SHALL be stored at wptr+j, and wptr and count SHALL advance by write_num_i.
REQ-016 write_num_i = 3 SHALL be treated as 2.
REQ-017 read_valid_o[k] SHALL be (count > k); read_data_o[k] SHALL be the entry at rptr+k, combinational, with first-word fall-through and zero-cycle latency.
REQ-018 When read_ready_i is 1, pop SHALL be min(read_num_i, count, 2) and rptr SHALL advance by pop; when read_ready_i is 0, pop = 0.
REQ-019 In the same cycle, count SHALL update to count + accepted_writes - pop.
REQ-020 A write to an empty queue SHALL become visible on read_valid_o the next cycle, not the same cycle.
REQ-021 flush_i SHALL reset rptr, wptr and count to 0 at the next edge, overriding any same-cycle write or pop. read_valid_o SHALL NOT be gated by flush_i in the flush cycle; the consumer masks it.
REQ-022 Pointer arithmetic SHALL wrap modulo DEPTH for both lanes: at wptr = DEPTH-1, lane 1 goes to entry 0.
REQ-023 Overflow SHALL be impossible by construction (REQ-014). Underflow SHALL be impossible by the clamp in REQ-018.

Reset
REQ-024 While rst is high, rptr, wptr and count SHALL be 0, asynchronously, regardless of clk.
REQ-025 During and after reset, write_ready_o = 1 and read_valid_o = 2'b00. read_data_o is don't-care.
REQ-026 Storage SHALL NOT be reset.
REQ-027 Reset asserted mid-operation SHALL drop all entries, identical to flush.

Structure
REQ-028 inst_package_t (pc, inst, fetch_excp, bpu_predict) SHALL live in the shared pipeline package. No new constants are needed beyond the parameters.
REQ-029 Storage SHALL be split into 2 banks by entry index LSB, so each lane reads and writes one bank per cycle without a 4-port RAM.
REQ-030 One sub-module, core_inst_queue_bank, SHALL implement a 1-write/1-read bank of DEPTH/2 entries with asynchronous read; it is instantiated twice.

Verification
REQ-031 Reset, then write 2 entries {A,B}; next cycle: read_valid_o = 11, lane0 = A, lane1 = B, and count = 2 is visible via write_ready_o = 1.
REQ-032 Fill with 15 entries (write_num 2,2,...,1): write_ready_o = 0 at count 15; a write of 2 offered then is not accepted; after pop 2, write_ready_o = 1.
REQ-033 count = 1 and read_num_i = 2 with read_ready_i = 1: only 1 popped, next read_valid_o = 00, no pointer corruption.
REQ-034 Simultaneous write 2 and pop 2 at count = 3 for 20 cycles, crossing wrap at index 15 -> 0: order preserved, count stays 3.
REQ-035 flush_i with count = 9 and a concurrent write of 2: next cycle read_valid_o = 00, write_ready_o = 1, and the flushed-cycle data never appears.
REQ-036 rst pulsed between clock edges with count = 5: read_valid_o = 00 before the next edge, and normal operation resumes afterwards.
